// File: rtl/gpu_blit.sv
// XOR sprite blitter for a 1bpp framebuffer that shares one memory port with the sprite data.
// It also runs a framebuffer clear command. Clip or wrap at the screen edges.
module gpu_blit #(
    parameter int          WIDTH   = 64,
    parameter int          HEIGHT  = 32,
    parameter logic [11:0] FB_BASE = 12'h100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      draw,
    input  logic                      clear,
    input  logic                      wrap,
    input  logic                      wide,
    input  logic [11:0]               addr,
    input  logic [3:0]                lines,
    input  logic [$clog2(WIDTH)-1:0]  x,
    input  logic [$clog2(HEIGHT)-1:0] y,
    output logic                      busy,
    output logic                      collision,
    output logic                      mem_read,
    output logic [11:0]               mem_read_idx,
    input  logic [7:0]                mem_read_byte,
    input  logic                      mem_read_ack,
    output logic                      mem_write,
    output logic [11:0]               mem_write_idx,
    output logic [7:0]                mem_write_byte
);
    localparam int XW       = $clog2(WIDTH);
    localparam int YW       = $clog2(HEIGHT);
    localparam int CBW      = XW - 3;
    localparam int COLS     = WIDTH / 8;
    localparam int FB_BYTES = WIDTH * HEIGHT / 8;
    localparam int CCW      = $clog2(FB_BYTES) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ROW, S_SRD, S_SACK, S_BYTE, S_FACK, S_CLR} state_t;

    state_t          state_r, state_n;
    logic [11:0]     addr_r, addr_n;
    logic [4:0]      n_r, n_n, row_r, row_n;
    logic            wrap_r, wrap_n, wide_r, wide_n, half_r, half_n;
    logic [XW-1:0]   x0_r, x0_n;
    logic [YW-1:0]   y0_r, y0_n;
    logic [1:0]      k_r, k_n;
    logic [7:0]      spr_hi_r, spr_hi_n, spr_lo_r, spr_lo_n;
    logic [CCW-1:0]  clr_cnt_r, clr_cnt_n;
    logic            busy_r, busy_n, collision_r, collision_n;
    logic            mem_read_r, mem_read_n, mem_write_r, mem_write_n;
    logic [11:0]     rd_idx_r, rd_idx_n, wr_idx_r, wr_idx_n;
    logic [7:0]      wr_byte_r, wr_byte_n;

    logic [23:0]     spr_bits_s;
    logic [7:0]      spr_byte_s;
    logic [1:0]      nbytes_s;
    logic [15:0]     row_abs_s, col_abs_s;
    logic            row_clip_s, col_clip_s;
    logic [YW-1:0]   row_eff_s;
    logic [CBW-1:0]  col_eff_s;
    logic [11:0]     fb_addr_s, spr_addr_s;

    assign busy           = busy_r;
    assign collision      = collision_r;
    assign mem_read       = mem_read_r;
    assign mem_read_idx   = rd_idx_r;
    assign mem_write      = mem_write_r;
    assign mem_write_idx  = wr_idx_r;
    assign mem_write_byte = wr_byte_r;

    // Sprite row alignment and framebuffer/sprite address arithmetic for the current row and byte.
    always_comb begin
        if (wide_r) begin
            spr_bits_s = {spr_hi_r, spr_lo_r, 8'h00} >> x0_r[2:0];
            nbytes_s   = 2'd3;
        end else begin
            spr_bits_s = {spr_hi_r, 16'h0000} >> x0_r[2:0];
            nbytes_s   = 2'd2;
        end
        case (k_r)
            2'd0:    spr_byte_s = spr_bits_s[23:16];
            2'd1:    spr_byte_s = spr_bits_s[15:8];
            2'd2:    spr_byte_s = spr_bits_s[7:0];
            default: spr_byte_s = 8'h00;
        endcase
        // Power-of-two screen: keeping the low bits is the wrap; clipped rows/bytes never get here.
        row_abs_s  = 16'(y0_r) + 16'(row_r);
        col_abs_s  = 16'(x0_r[XW-1:3]) + 16'(k_r);
        row_clip_s = (row_abs_s >= 16'(HEIGHT));
        col_clip_s = (col_abs_s >= 16'(COLS));
        row_eff_s  = row_abs_s[YW-1:0];
        col_eff_s  = col_abs_s[CBW-1:0];
        fb_addr_s  = FB_BASE + 12'(row_eff_s) * 12'(COLS) + 12'(col_eff_s);
        if (wide_r) begin
            spr_addr_s = addr_r + {6'b0, row_r, 1'b0} + {11'b0, half_r};
        end else begin
            spr_addr_s = addr_r + {7'b0, row_r};
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_n     = state_r;
        addr_n      = addr_r;
        n_n         = n_r;
        row_n       = row_r;
        wrap_n      = wrap_r;
        wide_n      = wide_r;
        half_n      = half_r;
        x0_n        = x0_r;
        y0_n        = y0_r;
        k_n         = k_r;
        spr_hi_n    = spr_hi_r;
        spr_lo_n    = spr_lo_r;
        clr_cnt_n   = clr_cnt_r;
        collision_n = collision_r;
        mem_read_n  = 1'b0;
        mem_write_n = 1'b0;
        rd_idx_n    = rd_idx_r;
        wr_idx_n    = wr_idx_r;
        wr_byte_n   = wr_byte_r;
        case (state_r)
            S_IDLE: begin
                if (clear) begin
                    state_n     = S_CLR;
                    clr_cnt_n   = '0;
                    collision_n = 1'b0;
                end else if (draw) begin
                    state_n     = S_ROW;
                    addr_n      = addr;
                    n_n         = (wide && lines == 4'd0) ? 5'd16 : {1'b0, lines};
                    wrap_n      = wrap;
                    wide_n      = wide;
                    x0_n        = x;
                    y0_n        = y;
                    row_n       = 5'd0;
                    collision_n = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_ROW: begin
                if (row_r == n_r) begin
                    state_n = S_IDLE;
                end else if (!wrap_r && row_clip_s) begin
                    row_n = row_r + 5'd1;
                end else begin
                    state_n = S_SRD;
                    half_n  = 1'b0;
                end
            end
            S_SRD: begin
                mem_read_n = 1'b1;
                rd_idx_n   = spr_addr_s;
                state_n    = S_SACK;
            end
            S_SACK: begin
                if (mem_read_ack) begin
                    if (wide_r && !half_r) begin
                        spr_hi_n = mem_read_byte;
                        half_n   = 1'b1;
                        state_n  = S_SRD;
                    end else if (wide_r) begin
                        spr_lo_n = mem_read_byte;
                        k_n      = 2'd0;
                        state_n  = S_BYTE;
                    end else begin
                        spr_hi_n = mem_read_byte;
                        k_n      = 2'd0;
                        state_n  = S_BYTE;
                    end
                end else begin
                    state_n = S_SACK;
                end
            end
            S_BYTE: begin
                if (k_r == nbytes_s) begin
                    row_n   = row_r + 5'd1;
                    state_n = S_ROW;
                end else if (spr_byte_s == 8'h00 || (!wrap_r && col_clip_s)) begin
                    k_n = k_r + 2'd1;
                end else begin
                    mem_read_n = 1'b1;
                    rd_idx_n   = fb_addr_s;
                    state_n    = S_FACK;
                end
            end
            S_FACK: begin
                if (mem_read_ack) begin
                    mem_write_n = 1'b1;
                    wr_idx_n    = fb_addr_s;
                    wr_byte_n   = mem_read_byte ^ spr_byte_s;
                    if ((mem_read_byte & spr_byte_s) != 8'h00) begin
                        collision_n = 1'b1;
                    end else begin
                        collision_n = collision_r;
                    end
                    k_n     = k_r + 2'd1;
                    state_n = S_BYTE;
                end else begin
                    state_n = S_FACK;
                end
            end
            S_CLR: begin
                mem_write_n = 1'b1;
                wr_idx_n    = FB_BASE + 12'(clr_cnt_r);
                wr_byte_n   = 8'h00;
                if (clr_cnt_r == CCW'(FB_BYTES - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    clr_cnt_n = clr_cnt_r + {{(CCW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Keep busy up while the final clear write is still on the port.
        busy_n = (state_n != S_IDLE) || mem_write_n;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            addr_r      <= 12'h000;
            n_r         <= 5'd0;
            row_r       <= 5'd0;
            wrap_r      <= 1'b0;
            wide_r      <= 1'b0;
            half_r      <= 1'b0;
            x0_r        <= '0;
            y0_r        <= '0;
            k_r         <= 2'd0;
            spr_hi_r    <= 8'h00;
            spr_lo_r    <= 8'h00;
            clr_cnt_r   <= '0;
            busy_r      <= 1'b0;
            collision_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            rd_idx_r    <= 12'h000;
            wr_idx_r    <= 12'h000;
            wr_byte_r   <= 8'h00;
        end else begin
            state_r     <= state_n;
            addr_r      <= addr_n;
            n_r         <= n_n;
            row_r       <= row_n;
            wrap_r      <= wrap_n;
            wide_r      <= wide_n;
            half_r      <= half_n;
            x0_r        <= x0_n;
            y0_r        <= y0_n;
            k_r         <= k_n;
            spr_hi_r    <= spr_hi_n;
            spr_lo_r    <= spr_lo_n;
            clr_cnt_r   <= clr_cnt_n;
            busy_r      <= busy_n;
            collision_r <= collision_n;
            mem_read_r  <= mem_read_n;
            mem_write_r <= mem_write_n;
            rd_idx_r    <= rd_idx_n;
            wr_idx_r    <= wr_idx_n;
            wr_byte_r   <= wr_byte_n;
        end
    end
endmodule

// File: tb/tb_gpu_blit.sv
// Directed bench for gpu_blit at 64x32 with the framebuffer at 0x100.
// A behavioural memory model answers reads after a configurable delay.
module tb_gpu_blit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        draw = 1'b0, clear = 1'b0, wrap = 1'b0, wide = 1'b0;
    logic [11:0] addr = 12'h000;
    logic [3:0]  lines = 4'd0;
    logic [5:0]  x = 6'd0;
    logic [4:0]  y = 5'd0;
    logic        busy, collision, mem_read, mem_write, mem_read_ack;
    logic [11:0] mem_read_idx, mem_write_idx;
    logic [7:0]  mem_read_byte, mem_write_byte;

    logic [7:0]  mem [0:4095];
    logic        rd_pend = 1'b0;
    logic [11:0] rd_addr = 12'h000;
    int          rd_wait = 0, lat = 1, n_reads = 0, rw_overlap = 0;
    int          n_checks = 0, n_fail = 0;

    gpu_blit dut (
        .clk(clk), .rst_n(rst_n), .draw(draw), .clear(clear), .wrap(wrap), .wide(wide),
        .addr(addr), .lines(lines), .x(x), .y(y), .busy(busy), .collision(collision),
        .mem_read(mem_read), .mem_read_idx(mem_read_idx), .mem_read_byte(mem_read_byte),
        .mem_read_ack(mem_read_ack), .mem_write(mem_write), .mem_write_idx(mem_write_idx),
        .mem_write_byte(mem_write_byte)
    );

    always #5 clk = ~clk;

    // Shared memory: writes land at the edge, reads return after lat+1 cycles.
    initial mem_read_ack = 1'b0;
    initial mem_read_byte = 8'h00;
    always @(posedge clk) begin
        mem_read_ack <= 1'b0;
        if (mem_write) mem[mem_write_idx] = mem_write_byte;
        if (mem_read && mem_write) rw_overlap++;
        if (rd_pend) begin
            if (rd_wait <= 1) begin
                mem_read_ack  <= 1'b1;
                mem_read_byte <= mem[rd_addr];
                rd_pend = 1'b0;
            end else begin
                rd_wait--;
            end
        end
        if (mem_read) begin
            rd_pend = 1'b1;
            rd_addr = mem_read_idx;
            rd_wait = lat;
            n_reads++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic d, input logic c, input logic [11:0] a, input logic [3:0] l,
                          input logic [5:0] xx, input logic [4:0] yy, input logic wr, input logic wd,
                          output int cyc);
        @(negedge clk);
        addr = a; lines = l; x = xx; y = yy; wrap = wr; wide = wd; draw = d; clear = c;
        @(negedge clk);
        draw = 1'b0; clear = 1'b0; cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 5000) chk("op_timeout", 32'(cyc), 32'd0);
    endtask

    int cyc, bad, reads0, wcnt;
    logic [7:0] exp_b;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h042] = 8'hFF; mem[12'h043] = 8'hC3; mem[12'h044] = 8'hC3;
        mem[12'h045] = 8'hC3; mem[12'h046] = 8'hFF;
        for (int i = 12'h050; i <= 12'h06F; i++) mem[i] = 8'hFF;
        mem[12'h200] = 8'h5A;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_coll", 32'(collision), 32'd0);
        chk("rst_rd", 32'(mem_read), 32'd0);
        chk("rst_wr", 32'(mem_write), 32'd0);
        chk("rst_idx", {8'h00, mem_read_idx, mem_write_idx}, 32'd0);
        rst_n = 1'b1;

        // Basic draw, then redraw erases and collides
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        chk("d1_100", 32'(mem[12'h100]), 32'hFF);
        chk("d1_108", 32'(mem[12'h108]), 32'hC3);
        chk("d1_110", 32'(mem[12'h110]), 32'hC3);
        chk("d1_118", 32'(mem[12'h118]), 32'hC3);
        chk("d1_120", 32'(mem[12'h120]), 32'hFF);
        chk("d1_101", 32'(mem[12'h101]), 32'h00);
        chk("d1_coll", 32'(collision), 32'd0);
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        chk("d2_100", 32'(mem[12'h100]), 32'h00);
        chk("d2_118", 32'(mem[12'h118]), 32'h00);
        chk("d2_coll", 32'(collision), 32'd1);
        run_op(1'b0, 1'b1, 12'h000, 4'd0, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        chk("clr_coll", 32'(collision), 32'd0);

        // Right edge: clip then wrap (slower memory for the wrap case)
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd61, 5'd0, 1'b0, 1'b0, cyc);
        chk("xc_107", 32'(mem[12'h107]), 32'h07);
        chk("xc_10F", 32'(mem[12'h10F]), 32'h06);
        chk("xc_108", 32'(mem[12'h108]), 32'h00);
        chk("xc_127", 32'(mem[12'h127]), 32'h07);
        run_op(1'b0, 1'b1, 12'h000, 4'd0, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        lat = 3;
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd61, 5'd0, 1'b1, 1'b0, cyc);
        lat = 1;
        chk("xw_107", 32'(mem[12'h107]), 32'h07);
        chk("xw_100", 32'(mem[12'h100]), 32'hF8);
        chk("xw_108", 32'(mem[12'h108]), 32'h18);

        // Bottom edge: clip then wrap
        run_op(1'b0, 1'b1, 12'h000, 4'd0, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd0, 5'd28, 1'b0, 1'b0, cyc);
        chk("yc_1E0", 32'(mem[12'h1E0]), 32'hFF);
        chk("yc_1E8", 32'(mem[12'h1E8]), 32'hC3);
        chk("yc_1F8", 32'(mem[12'h1F8]), 32'hC3);
        chk("yc_200", 32'(mem[12'h200]), 32'h5A);
        chk("yc_100", 32'(mem[12'h100]), 32'h00);
        run_op(1'b0, 1'b1, 12'h000, 4'd0, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd0, 5'd28, 1'b1, 1'b0, cyc);
        chk("yw_1E0", 32'(mem[12'h1E0]), 32'hFF);
        chk("yw_100", 32'(mem[12'h100]), 32'hFF);
        chk("yw_200", 32'(mem[12'h200]), 32'h5A);

        // 16x16 sprite at x=4
        run_op(1'b0, 1'b1, 12'h000, 4'd0, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        run_op(1'b1, 1'b0, 12'h050, 4'd0, 6'd4, 5'd0, 1'b0, 1'b1, cyc);
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 4; k++) begin
                exp_b = (k == 0) ? 8'h0F : (k == 1) ? 8'hFF : (k == 2) ? 8'hF0 : 8'h00;
                if (mem[12'h100 + 12'(8 * r + k)] !== exp_b) bad++;
            end
        end
        chk("wide_bad", 32'(bad), 32'd0);
        chk("wide_row16", 32'(mem[12'h180]), 32'h00);
        chk("wide_coll", 32'(collision), 32'd0);
        run_op(1'b1, 1'b0, 12'h050, 4'd0, 6'd4, 5'd0, 1'b0, 1'b1, cyc);
        chk("wide2_coll", 32'(collision), 32'd1);

        // Empty narrow sprite: one busy cycle, no memory access
        reads0 = n_reads;
        run_op(1'b1, 1'b0, 12'h042, 4'd0, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        chk("l0_cyc", 32'(cyc), 32'd1);
        chk("l0_reads", 32'(n_reads - reads0), 32'd0);
        chk("l0_coll", 32'(collision), 32'd0);

        // Clear wins over draw; a draw while busy is ignored
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        @(negedge clk);
        addr = 12'h042; lines = 4'd5; x = 6'd0; y = 5'd0; wrap = 1'b0; wide = 1'b0;
        draw = 1'b1; clear = 1'b1;
        @(negedge clk);
        draw = 1'b0; clear = 1'b0; cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            draw = (cyc == 10);
            @(negedge clk);
        end
        draw = 1'b0;
        chk("cd_cyc_ge256", 32'(cyc >= 256), 32'd1);
        repeat (5) @(negedge clk);
        chk("cd_idle", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 12'h100; i < 12'h200; i++) if (mem[i] !== 8'h00) bad++;
        chk("cd_nonzero", 32'(bad), 32'd0);
        chk("cd_200", 32'(mem[12'h200]), 32'h5A);

        // Reset in the middle of a colliding draw
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        @(negedge clk);
        draw = 1'b1;
        @(negedge clk);
        draw = 1'b0; wcnt = 0;
        while (!mem_write && wcnt < 200) begin
            @(negedge clk);
            wcnt++;
        end
        if (wcnt >= 200) chk("mid_timeout", 32'(wcnt), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("mid_coll", 32'(collision), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b1, 12'h000, 4'd0, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        run_op(1'b1, 1'b0, 12'h042, 4'd5, 6'd0, 5'd0, 1'b0, 1'b0, cyc);
        chk("post_100", 32'(mem[12'h100]), 32'hFF);
        chk("post_110", 32'(mem[12'h110]), 32'hC3);
        chk("post_120", 32'(mem[12'h120]), 32'hFF);
        chk("post_coll", 32'(collision), 32'd0);
        chk("rw_overlap", 32'(rw_overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
